// File: rtl/vga_text_writer.sv
// Text-mode character writer for a COLS x ROWS character RAM.
// Accepts one character code per handshake, interprets the small set of
// control codes (LF, CR, BS), keeps the cursor, and drives single-port
// write strobes into the text RAM. Full-screen and single-row clears are
// performed one cell per cycle while the input handshake is held off.
module vga_text_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 60,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        clear_req,
    output logic        busy,
    output logic        mem_we,
    output logic [12:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_CLEAR_ALL = 2'd1;
    localparam logic [1:0] S_CLEAR_ROW = 2'd2;

    localparam logic [12:0] CELLS    = 13'(COLS * ROWS);
    localparam logic [12:0] COLS_W   = 13'(COLS);
    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);

    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_CR = 8'h0D;
    localparam logic [7:0] CODE_BS = 8'h08;

    logic [1:0]  state;
    logic [12:0] clr_cnt;

    logic accept;
    logic is_print;
    logic is_lf;
    logic is_cr;
    logic is_bs;

    // Linear cell address of (row, col) in the text RAM.
    function automatic logic [12:0] cell_addr(input logic [5:0] row,
                                              input logic [6:0] col);
        return 13'(row) * COLS_W + 13'(col);
    endfunction

    // Row after an advance; the screen wraps from the bottom row to the top.
    function automatic logic [5:0] next_row(input logic [5:0] row);
        return (row == LAST_ROW) ? 6'd0 : row + 6'd1;
    endfunction

    // A clear request waiting in IDLE blocks the character handshake.
    assign char_ready = (state == S_IDLE) && !clear_req;
    assign accept     = char_valid && char_ready;

    // Classify the offered code; anything unclassified is dropped silently.
    always_comb begin
        is_print = (char_data >= 8'h20) && (char_data <= 8'h7E);
        is_lf    = (char_data == CODE_LF);
        is_cr    = (char_data == CODE_CR);
        is_bs    = (char_data == CODE_BS);
    end

    // Control FSM, cursor and registered RAM write port.
    always_ff @(posedge clk25) begin
        if (rst) begin
            state      <= S_CLEAR_ALL;
            clr_cnt    <= 13'd0;
            busy       <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= 13'd0;
            mem_data   <= 8'd0;
            cursor_col <= 7'd0;
            cursor_row <= 6'd0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        state   <= S_CLEAR_ALL;
                        clr_cnt <= 13'd0;
                        busy    <= 1'b1;
                    end else if (accept) begin
                        if (is_print) begin
                            mem_we   <= 1'b1;
                            mem_addr <= cell_addr(cursor_row, cursor_col);
                            mem_data <= char_data;
                            if (cursor_col == LAST_COL) begin
                                cursor_col <= 7'd0;
                                cursor_row <= next_row(cursor_row);
                                state      <= S_CLEAR_ROW;
                                clr_cnt    <= 13'd0;
                                busy       <= 1'b1;
                            end else begin
                                cursor_col <= cursor_col + 7'd1;
                            end
                        end else if (is_lf) begin
                            cursor_col <= 7'd0;
                            cursor_row <= next_row(cursor_row);
                            state      <= S_CLEAR_ROW;
                            clr_cnt    <= 13'd0;
                            busy       <= 1'b1;
                        end else if (is_cr) begin
                            cursor_col <= 7'd0;
                        end else if (is_bs && (cursor_col != 7'd0)) begin
                            cursor_col <= cursor_col - 7'd1;
                            mem_we     <= 1'b1;
                            mem_addr   <= cell_addr(cursor_row, cursor_col - 7'd1);
                            mem_data   <= BLANK;
                        end
                    end
                end

                // One blank per cycle over the whole RAM; the extra cycle at
                // clr_cnt == CELLS lets the last write show while still busy.
                S_CLEAR_ALL: begin
                    if (clr_cnt == CELLS) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        cursor_col <= 7'd0;
                        cursor_row <= 6'd0;
                    end else begin
                        mem_we   <= 1'b1;
                        mem_addr <= clr_cnt;
                        mem_data <= BLANK;
                        clr_cnt  <= clr_cnt + 13'd1;
                    end
                end

                // Blank the row the cursor has just moved onto.
                S_CLEAR_ROW: begin
                    if (clr_cnt == COLS_W) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        mem_we   <= 1'b1;
                        mem_addr <= cell_addr(cursor_row, 7'd0) + clr_cnt;
                        mem_data <= BLANK;
                        clr_cnt  <= clr_cnt + 13'd1;
                    end
                end

                default: begin
                    state   <= S_CLEAR_ALL;
                    clr_cnt <= 13'd0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Bench for vga_text_writer: a screen-level model predicts every RAM write
// into a queue; a monitor pops and compares on each observed write strobe.
module tb_vga_text_writer;

    logic        clk25 = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        clear_req = 1'b0;
    logic        busy;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_data;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;

    int checks = 0;
    int errors = 0;

    // Expected writes as {addr[12:0], data[7:0]}
    logic [20:0] exp_q[$];

    // Reference cursor
    int m_col = 0;
    int m_row = 0;

    vga_text_writer #(.COLS(80), .ROWS(60), .BLANK(8'h20)) dut (
        .clk25     (clk25),
        .rst       (rst),
        .char_valid(char_valid),
        .char_data (char_data),
        .char_ready(char_ready),
        .clear_req (clear_req),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row)
    );

    always #20 clk25 = ~clk25;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the expectation queue
    always @(negedge clk25) begin
        if (!rst && mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write at %0t",
                         mem_addr, mem_data, $time);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                check("write_addr", int'(mem_addr), int'(e[20:8]));
                check("write_data", int'(mem_data), int'(e[7:0]));
            end
        end
    end

    function automatic void push_w(input int addr, input int data);
        exp_q.push_back({13'(addr), 8'(data)});
    endfunction

    function automatic void model_clear_all();
        for (int a = 0; a < 4800; a++) push_w(a, 8'h20);
        m_col = 0;
        m_row = 0;
    endfunction

    function automatic void model_advance();
        m_row = (m_row + 1) % 60;
        for (int i = 0; i < 80; i++) push_w(m_row * 80 + i, 8'h20);
    endfunction

    // Screen behaviour of one accepted code
    function automatic void model_char(input int c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_w(m_row * 80 + m_col, c);
            m_col++;
            if (m_col == 80) begin
                m_col = 0;
                model_advance();
            end
        end else if (c == 8'h0A) begin
            m_col = 0;
            model_advance();
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_w(m_row * 80 + m_col, 8'h20);
            end
        end
    endfunction

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!(busy == 1'b0 && char_ready == 1'b1) && n < budget) begin
            @(posedge clk25); #1;
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", tag, n);
        end
        @(posedge clk25); #1;
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_col"}, int'(cursor_col), m_col);
        check({tag, "_row"}, int'(cursor_row), m_row);
    endtask

    task automatic send(input int c);
        int n = 0;
        while (!char_ready && n < 200) begin
            @(posedge clk25); #1;
            n++;
        end
        if (!char_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready_timeout: char_ready %0d, expected 1", char_ready);
        end
        char_valid = 1'b1;
        char_data  = 8'(c);
        model_char(c);
        @(posedge clk25); #1;
        char_valid = 1'b0;
    endtask

    task automatic goto(input int col, input int row);
        send(8'h0D);
        wait_idle(200, "goto_cr");
        for (int k = 0; k < 60 && m_row != row; k++) begin
            send(8'h0A);
            wait_idle(200, "goto_lf");
        end
        for (int k = 0; k < col; k++) begin
            send($urandom_range(8'h21, 8'h7E));
            wait_idle(200, "goto_ch");
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk25);
        #1;
        check("rst_we", int'(mem_we), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_data", int'(mem_data), 0);
        check("rst_col", int'(cursor_col), 0);
        check("rst_row", int'(cursor_row), 0);
        check("rst_ready", int'(char_ready), 0);

        // Power-up clear
        model_clear_all();
        rst = 1'b0;
        @(posedge clk25); #1;
        check("pwr_busy", int'(busy), 1);
        check("pwr_first_we", int'(mem_we), 1);
        check("pwr_first_addr", int'(mem_addr), 0);
        wait_idle(6000, "pwr_clear");
        check("pwr_ready", int'(char_ready), 1);
        check("pwr_busy_low", int'(busy), 0);

        // Single character at home, latency 1
        send(8'h41);
        check("a_we", int'(mem_we), 1);
        check("a_addr", int'(mem_addr), 0);
        check("a_data", int'(mem_data), 8'h41);
        wait_idle(200, "a");

        // Fill row 0, wrap, row 1 cleared with handshake held off
        for (int k = 0; k < 79; k++) send($urandom_range(8'h20, 8'h7E));
        check("wrap_busy", int'(busy), 1);
        check("wrap_ready", int'(char_ready), 0);
        repeat (40) @(posedge clk25);
        #1;
        check("wrap_ready_mid", int'(char_ready), 0);
        wait_idle(200, "wrap");

        // Randomised code stream
        for (int k = 0; k < 300; k++) begin
            int r;
            int c;
            r = $urandom_range(0, 99);
            if (r < 70)      c = $urandom_range(8'h20, 8'h7E);
            else if (r < 78) c = 8'h0A;
            else if (r < 84) c = 8'h0D;
            else if (r < 94) c = 8'h08;
            else             c = $urandom_range(0, 255);
            send(c);
            wait_idle(200, "rand");
        end

        // LF on the bottom row wraps to row 0; clear_req/char ignored meanwhile
        goto(5, 59);
        send(8'h0A);
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h5A;
        repeat (3) begin
            check("clrrow_ready", int'(char_ready), 0);
            @(posedge clk25); #1;
        end
        clear_req  = 1'b0;
        char_valid = 1'b0;
        wait_idle(200, "bottom_lf");

        // Backspace mid-row, then at column 0
        goto(3, 2);
        send(8'h08);
        check("bs_we", int'(mem_we), 1);
        check("bs_addr", int'(mem_addr), 162);
        check("bs_data", int'(mem_data), 8'h20);
        wait_idle(200, "bs");
        goto(0, 2);
        send(8'h08);
        check("bs0_we", int'(mem_we), 0);
        wait_idle(200, "bs0");

        // clear_req beats char_valid in IDLE
        goto(7, 9);
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h42;
        model_clear_all();
        @(posedge clk25); #1;
        clear_req  = 1'b0;
        char_valid = 1'b0;
        check("clr_busy", int'(busy), 1);
        check("clr_no_char_we", int'(mem_we), 0);
        wait_idle(6000, "clear_all");

        // Reset in the middle of a row clear restarts the full clear
        goto(10, 20);
        send(8'h0A);
        repeat (10) @(posedge clk25);
        #1;
        rst = 1'b1;
        @(posedge clk25); #1;
        check("midrst_we", int'(mem_we), 0);
        check("midrst_busy", int'(busy), 1);
        check("midrst_col", int'(cursor_col), 0);
        check("midrst_row", int'(cursor_row), 0);
        exp_q.delete();
        model_clear_all();
        rst = 1'b0;
        @(posedge clk25); #1;
        check("midrst_restart_addr", int'(mem_addr), 0);
        wait_idle(6000, "midrst_clear");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_text_writer.md
VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

Interface
REQ-001 SHALL have parameters: COLS 80, text columns; ROWS 60, text rows; BLANK 8'h20, clear character code.
REQ-002 SHALL have port clk25  in  1  pixel/system clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port char_valid  in  1  character request valid.
REQ-005 SHALL have port char_data  in  8  character code.
REQ-006 SHALL have port char_ready  out  1  combinational; equals (state==IDLE) && !clear_req.
REQ-007 SHALL have port clear_req  in  1  full-screen clear request; sampled only in IDLE.
REQ-008 SHALL have port busy  out  1  registered; high in CLEAR_ALL or CLEAR_ROW.
REQ-009 SHALL have port mem_we  out  1  registered text-RAM write enable.
REQ-010 SHALL have port mem_addr  out  13  registered cell address, row*COLS+col.
REQ-011 SHALL have port mem_data  out  8  registered character written.
REQ-012 SHALL have port cursor_col  out  7  current column, 0..79.
REQ-013 SHALL have port cursor_row  out  6  current row, 0..59.

Function
REQ-014 SHALL implement states IDLE, CLEAR_ALL, CLEAR_ROW.
REQ-015 SHALL accept a character only on a rising edge with char_valid && char_ready; the accepted character's write appears on mem_we/mem_addr/mem_data in the following cycle (latency 1).
REQ-016 SHALL hold mem_we low in every cycle with no write, including non-writing accepted codes.
REQ-017 SHALL, for printable codes 0x20-0x7E, write char_data at the cursor, then col+1; at col 79: col=0, row advance.
REQ-018 SHALL, for 0x0A (LF), set col=0 and advance the row, with no character write.
REQ-019 SHALL, for 0x0D (CR), set col=0, with no write and no row change.
REQ-020 SHALL, for 0x08 (BS) with col>0, set col-1 and write BLANK at the new cursor cell; with col==0, do nothing.
REQ-021 SHALL accept and discard all other codes, with no write and no cursor change.
REQ-022 SHALL perform a row advance as row+1, wrapping 59->0, then enter CLEAR_ROW.
REQ-023 SHALL, in CLEAR_ROW, write BLANK to cells newrow*80+0..79, one per cycle for 80 consecutive cycles, then return to IDLE; the cursor is already at (0,newrow).
REQ-024 SHALL, in CLEAR_ROW and CLEAR_ALL, hold char_ready low and ignore clear_req (not latched).
REQ-025 SHALL, when clear_req is high in IDLE, give it priority over char_valid in the same cycle (char not accepted) and enter CLEAR_ALL.
REQ-026 SHALL, in CLEAR_ALL, write BLANK to addresses 0..4799 ascending, one per cycle (4800 cycles), then set cursor (0,0) and return to IDLE.
REQ-027 SHALL compute addresses in 13 bits; the maximum address is 4799, and no address >=4800 is ever driven with mem_we high.
REQ-028 SHALL make busy fall in the cycle after the last clear write; char_ready rises in that same cycle.

Reset
REQ-029 SHALL, while rst is high at a clock edge, force mem_we=0, mem_addr=0, mem_data=0, cursor (0,0), clear counter 0, and state CLEAR_ALL, aborting any operation in progress.
REQ-030 SHALL begin the power-up clear on the first edge after rst falls (addr 0); busy reads 1 from the first cycle after reset.

Verification
REQ-031 SHALL pass: release reset -> 4800 consecutive writes, addr 0..4799, data 0x20; then busy=0, char_ready=1, cursor (0,0).
REQ-032 SHALL pass: at (0,0) send 0x41 -> next cycle mem_we=1, addr 0, data 0x41; cursor (1,0).
REQ-033 SHALL pass: 80 printable chars on row 0 -> last write addr 79; cursor (0,1); 80 blank writes addr 80..159 with char_ready low; then IDLE.
REQ-034 SHALL pass: cursor (5,59), send 0x0A -> cursor (0,0), no char write, blanks to addr 0..79.
REQ-035 SHALL pass: cursor (3,2), send 0x08 -> write 0x20 at addr 162, cursor (2,2); at (0,2), 0x08 -> no write, cursor unchanged.
REQ-036 SHALL pass: in IDLE, clear_req and char_valid high together -> char not accepted, CLEAR_ALL starts; rst asserted mid-CLEAR_ROW -> next cycle mem_we=0, then clear restarts at addr 0.
